// File: rtl/colour_step_ctrl_if.sv
// colour_step_ctrl_if: control, seek handshake and colour feedback bundle between
// board control, colour_step_ctrl and the colour counter.
interface colour_step_ctrl_if #(
    parameter int DWELL_W = 8
);
    logic               en;
    logic [DWELL_W-1:0] dwell;
    logic               seek_valid;
    logic [2:0]         seek_colour;
    logic               seek_ready;
    logic               resume;
    logic [2:0]         colour;
    logic               button;
    logic               arrived;
    logic               seek_err;
    logic               fault;
    logic [1:0]         state;

    modport slave (
        input  en, dwell, seek_valid, seek_colour, resume, colour,
        output seek_ready, button, arrived, seek_err, fault, state
    );

    modport master (
        output en, dwell, seek_valid, seek_colour, resume, colour,
        input  seek_ready, button, arrived, seek_err, fault, state
    );
endinterface

// File: rtl/colour_step_ctrl.sv
// colour_step_ctrl: drives the colour counter's button for dwell-paced free-run and seek-and-park.
// Optional COLOUR_CHECK_EN: an illegal colour feedback (0 or 7) raises the sticky fault.
module colour_step_ctrl #(
    parameter int DWELL_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    colour_step_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, SEEK = 2'd2, HOLD = 2'd3} state_t;

    state_t             r_state, w_state_n;
    logic [DWELL_W-1:0] r_cnt, w_cnt_n, w_dmax;
    logic [2:0]         r_steps, w_steps_n, r_target, w_target_n;
    logic               r_arrived, w_arrived_n, r_seek_err, w_seek_err_n, r_fault, w_fault_n;
    logic               w_colour_bad, w_accept, w_legal;

    assign w_dmax = (bus.dwell == '0) ? '0 : bus.dwell - 1'b1;
`ifdef COLOUR_CHECK_EN
    assign w_colour_bad = (bus.colour == 3'd0) || (bus.colour == 3'd7);
`else
    assign w_colour_bad = 1'b0;
`endif
    assign bus.seek_ready = bus.en & ~r_fault & (r_state != SEEK);
    assign w_accept       = bus.seek_valid & bus.seek_ready;
    assign w_legal        = (bus.seek_colour != 3'd0) && (bus.seek_colour != 3'd7);
    assign bus.button     = (r_state == RUN)  ? (r_cnt == w_dmax) :
                            (r_state == SEEK) ? (bus.colour != r_target) : 1'b0;
    assign bus.arrived    = r_arrived;
    assign bus.seek_err   = r_seek_err;
    assign bus.fault      = r_fault;
    assign bus.state      = r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_steps    <= '0;
            r_target   <= '0;
            r_arrived  <= 1'b0;
            r_seek_err <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_cnt      <= w_cnt_n;
            r_steps    <= w_steps_n;
            r_target   <= w_target_n;
            r_arrived  <= w_arrived_n;
            r_seek_err <= w_seek_err_n;
            r_fault    <= w_fault_n;
        end
    end

    // Priority: enable, fault, seek handshake, resume, then per-state progress.
    always_comb begin
        w_state_n    = r_state;
        w_cnt_n      = r_cnt;
        w_steps_n    = r_steps;
        w_target_n   = r_target;
        w_arrived_n  = 1'b0;
        w_seek_err_n = 1'b0;
        w_fault_n    = r_fault | w_colour_bad;
        if (!bus.en) begin
            w_state_n = IDLE;
            w_cnt_n   = '0;
            w_steps_n = '0;
        end else if (w_fault_n) begin
            w_state_n = IDLE;
            w_cnt_n   = '0;
        end else if (w_accept) begin
            if (w_legal) begin
                w_state_n  = SEEK;
                w_target_n = bus.seek_colour;
                w_steps_n  = '0;
            end else begin
                w_seek_err_n = 1'b1;
            end
        end else if (r_state == HOLD && bus.resume) begin
            w_state_n = RUN;
            w_cnt_n   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_n = RUN;
                    w_cnt_n   = '0;
                end
                // A dwell shrunk below the running count restarts the period without a pulse.
                RUN: w_cnt_n = (r_cnt >= w_dmax) ? '0 : r_cnt + 1'b1;
                SEEK: begin
                    if (!bus.button) begin
                        w_arrived_n = 1'b1;
                        w_state_n   = HOLD;
                    end else begin
                        w_steps_n = r_steps + 3'd1;
                        if (r_steps == 3'd6) begin
                            w_fault_n = 1'b1;
                            w_state_n = IDLE;
                        end
                    end
                end
                default: w_state_n = r_state;
            endcase
        end
    end
endmodule

// File: tb/tb_colour_step_ctrl.sv
// tb_colour_step_ctrl: vector table, directed seek/fault/reset sequences and a randomized
// run against a rule-level model, with a colour counter stub closing the feedback loop.
module tb_colour_step_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    colour_step_ctrl_if #(.DWELL_W(8)) bus();
    colour_step_ctrl #(.DWELL_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    // Colour counter stub: 1..6 cycling on button, optionally overridden by a stuck value.
    logic [2:0] r_col;
    logic [2:0] stuck_val = 3'd1;
    logic       stuck = 1'b0;
    always_ff @(posedge clk) begin
        if (rst) r_col <= 3'd1;
        else if (bus.button) r_col <= (r_col == 3'd6) ? 3'd1 : r_col + 3'd1;
    end
    assign bus.colour = stuck ? stuck_val : r_col;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       en;
        logic [7:0] dwell;
        logic       btn;
        logic [1:0] st;
        logic [2:0] col;
    } vec_t;
    vec_t vt[$];

    function automatic void addv(input logic e, input logic [7:0] d, input logic b,
                                 input logic [1:0] s, input logic [2:0] c);
        vec_t v;
        v.en = e; v.dwell = d; v.btn = b; v.st = s; v.col = c;
        vt.push_back(v);
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic do_seek(input logic [2:0] tc, input int exp_n, input bit spam);
        int n = 0;
        int i = 0;
        int bad = 0;
        bus.seek_valid = 1'b1;
        bus.seek_colour = tc;
        #1;
        chk("seek_ready_free", int'(bus.seek_ready), 1);
        cyc();
        bus.seek_valid = spam;
        bus.seek_colour = 3'(int'(tc) % 6 + 1);
        #1;
        while (!bus.arrived && i < 12) begin
            n += int'(bus.button);
            if (bus.seek_ready) bad++;
            cyc();
            #1;
            i++;
        end
        bus.seek_valid = 1'b0;
        chk("seek_steps", n, exp_n);
        chk("seek_state_hold", int'(bus.state), 3);
        chk("seek_colour", int'(bus.colour), int'(tc));
        if (spam) chk("seek_ready_busy", bad, 0);
    endtask

    // Reference model: controller behaviour restated from its rules with plain ints.
    int m_st, m_cnt, m_steps, m_tgt;
    bit m_arr, m_err, m_flt;

    function automatic bit m_button(input int col, input int dw);
        int period = (dw == 0) ? 1 : dw;
        if (m_st == 1) return m_cnt == period - 1;
        if (m_st == 2) return col != m_tgt;
        return 1'b0;
    endfunction

    task automatic model_next(input bit r, input bit en, input bit sv, input int sc,
                              input bit res, input int col, input int dw);
        int period = (dw == 0) ? 1 : dw;
        bit btn = m_button(col, dw);
        bit rdy = en && !m_flt && m_st != 2;
        m_arr = 0;
        m_err = 0;
        if (r) begin
            m_st = 0; m_cnt = 0; m_steps = 0; m_tgt = 0; m_flt = 0;
            return;
        end
`ifdef COLOUR_CHECK_EN
        if (col == 0 || col == 7) m_flt = 1;
`endif
        if (!en) begin
            m_st = 0; m_cnt = 0; m_steps = 0;
        end else if (m_flt) begin
            m_st = 0; m_cnt = 0;
        end else if (sv && rdy) begin
            if (sc >= 1 && sc <= 6) begin
                m_tgt = sc; m_steps = 0; m_st = 2;
            end else m_err = 1;
        end else if (m_st == 3 && res) begin
            m_st = 1; m_cnt = 0;
        end else if (m_st == 0) begin
            m_st = 1; m_cnt = 0;
        end else if (m_st == 1) begin
            m_cnt = (m_cnt < period - 1) ? m_cnt + 1 : 0;
        end else if (m_st == 2) begin
            if (!btn) begin
                m_arr = 1; m_st = 3;
            end else begin
                m_steps++;
                if (m_steps == 7) begin
                    m_flt = 1; m_st = 0;
                end
            end
        end
    endtask

    initial begin
        int n;
        int bad;
        int i;
        logic [2:0] c0;
        bus.en = 1'b0;
        bus.dwell = 8'd0;
        bus.seek_valid = 1'b0;
        bus.seek_colour = 3'd0;
        bus.resume = 1'b0;

        // Free-run at dwell 3 from reset, then dwell 0 for continuous stepping.
        for (int c = 0; c < 12; c++)
            addv(1'b1, 8'd3, (c % 3 == 0 && c > 0), (c == 0) ? 2'd0 : 2'd1,
                 (c == 0) ? 3'd1 : 3'(1 + (c - 1) / 3));
        for (int c = 12; c < 20; c++)
            addv(1'b1, 8'd0, c >= 13, 2'd1, (c <= 13) ? 3'd4 : 3'(((c - 10) % 6) + 1));

        rst = 1'b1;
        cyc();
        cyc();
        #1;
        chk("rst_state", int'(bus.state), 0);
        chk("rst_button", int'(bus.button), 0);
        chk("rst_arrived", int'(bus.arrived), 0);
        chk("rst_seek_err", int'(bus.seek_err), 0);
        chk("rst_fault", int'(bus.fault), 0);
        chk("rst_seek_ready", int'(bus.seek_ready), 0);
        rst = 1'b0;
        foreach (vt[k]) begin
            bus.en = vt[k].en;
            bus.dwell = vt[k].dwell;
            #1;
            chk($sformatf("vec%0d_button", k), int'(bus.button), int'(vt[k].btn));
            chk($sformatf("vec%0d_state", k), int'(bus.state), int'(vt[k].st));
            chk($sformatf("vec%0d_colour", k), int'(bus.colour), int'(vt[k].col));
            cyc();
        end

        // Seeks: park, resume, wrap-around, busy rejection, zero-distance.
        do_reset();
        bus.en = 1'b1;
        bus.dwell = 8'd200;
        cyc();
        cyc();
        do_seek(3'd2, 1, 1'b0);
        bus.resume = 1'b1;
        cyc();
        bus.resume = 1'b0;
        #1;
        chk("resume_run", int'(bus.state), 1);
        do_seek(3'd5, 3, 1'b0);
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            cyc();
            #1;
            if (bus.colour != 3'd5 || bus.button || bus.arrived || bus.state != 2'd3) bad++;
        end
        chk("hold_frozen", bad, 0);
        bus.resume = 1'b1;
        cyc();
        bus.resume = 1'b0;
        #1;
        chk("resume_run2", int'(bus.state), 1);
        do_seek(3'd4, 5, 1'b0);
        do_seek(3'd2, 4, 1'b1);
        do_seek(3'd2, 0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            bus.seek_valid = 1'b1;
            bus.seek_colour = (k == 0) ? 3'd7 : 3'd0;
            cyc();
            bus.seek_valid = 1'b0;
            #1;
            chk("illegal_seek_err", int'(bus.seek_err), 1);
            chk("illegal_state", int'(bus.state), 3);
            cyc();
            #1;
            chk("illegal_err_pulse", int'(bus.seek_err), 0);
        end

        // Seek timeout against a stuck colour.
        stuck = 1'b1;
        stuck_val = 3'd3;
        bus.seek_valid = 1'b1;
        bus.seek_colour = 3'd6;
        cyc();
        bus.seek_valid = 1'b0;
        #1;
        n = 0;
        i = 0;
        while (bus.state != 2'd0 && i < 15) begin
            n += int'(bus.button);
            cyc();
            #1;
            i++;
        end
        chk("timeout_steps", n, 7);
        chk("timeout_fault", int'(bus.fault), 1);
        chk("timeout_ready", int'(bus.seek_ready), 0);
        bus.seek_valid = 1'b1;
        repeat (3) cyc();
        #1;
        chk("fault_sticky_state", int'(bus.state), 0);
        chk("fault_sticky_ready", int'(bus.seek_ready), 0);
        bus.seek_valid = 1'b0;
        stuck = 1'b0;
        do_reset();
        #1;
        chk("fault_cleared", int'(bus.fault), 0);

`ifdef COLOUR_CHECK_EN
        cyc();
        cyc();
        stuck = 1'b1;
        stuck_val = 3'd0;
        cyc();
        #1;
        chk("colour_check_fault", int'(bus.fault), 1);
        chk("colour_check_idle", int'(bus.state), 0);
        stuck = 1'b0;
        do_reset();
`endif

        // Reset in the middle of a seek.
        cyc();
        cyc();
        bus.seek_valid = 1'b1;
        bus.seek_colour = 3'd6;
        cyc();
        bus.seek_valid = 1'b0;
        cyc();
        #1;
        chk("midseek_state", int'(bus.state), 2);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        chk("midseek_rst_state", int'(bus.state), 0);
        chk("midseek_rst_button", int'(bus.button), 0);
        chk("midseek_rst_arrived", int'(bus.arrived), 0);
        chk("midseek_rst_err", int'(bus.seek_err), 0);
        chk("midseek_rst_fault", int'(bus.fault), 0);

        // Enable dropped mid-run.
        bus.dwell = 8'd2;
        repeat (5) cyc();
        bus.en = 1'b0;
        cyc();
        #1;
        chk("en_low_idle", int'(bus.state), 0);
        c0 = bus.colour;
        n = 0;
        for (int k = 0; k < 10; k++) begin
            n += int'(bus.button) + int'(bus.colour != c0);
            cyc();
            #1;
        end
        chk("en_low_quiet", n, 0);

        // Randomized run against the model.
        rst = 1'b1;
        #1;
        model_next(1'b1, 1'b0, 1'b0, 0, 1'b0, int'(bus.colour), int'(bus.dwell));
        cyc();
        for (int k = 0; k < 3000; k++) begin
            rst = ($urandom_range(0, 99) == 0);
            bus.en = ($urandom_range(0, 49) != 0);
            if ($urandom_range(0, 19) == 0) bus.dwell = 8'($urandom_range(0, 5));
            bus.seek_valid = ($urandom_range(0, 5) == 0);
            bus.seek_colour = 3'($urandom_range(0, 7));
            bus.resume = ($urandom_range(0, 7) == 0);
            if (!stuck && $urandom_range(0, 99) == 0) begin
                stuck = 1'b1;
                stuck_val = 3'($urandom_range(1, 6));
            end else if (stuck && $urandom_range(0, 9) == 0) stuck = 1'b0;
            #1;
            chk("rand_state", int'(bus.state), m_st);
            chk("rand_button", int'(bus.button), int'(m_button(int'(bus.colour), int'(bus.dwell))));
            chk("rand_ready", int'(bus.seek_ready), int'(bus.en && !m_flt && m_st != 2));
            chk("rand_arrived", int'(bus.arrived), int'(m_arr));
            chk("rand_seek_err", int'(bus.seek_err), int'(m_err));
            chk("rand_fault", int'(bus.fault), int'(m_flt));
            model_next(rst, bus.en, bus.seek_valid, int'(bus.seek_colour), bus.resume,
                       int'(bus.colour), int'(bus.dwell));
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/colour_step_ctrl.md
# colour_step_ctrl

Sequencer for the dynamic LED colour counter (3-bit colour cycling 1→6, skipping 0 and 7, advancing on each clock edge while `button` is high). It owns that counter's `button` input: in free-run it issues one-cycle step pulses at a programmable dwell rate, and on request it seeks to a target colour and parks there. It sits between the board/top-level control and the colour datapath, with the datapath's `colour` output fed back in.

## Interface
- `DWELL_W`, 8: width of the dwell count.
- `clk` in 1: sole clock; all state updates on posedge.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: run enable; low forces IDLE.
- `dwell` in DWELL_W: cycles per colour in RUN; 0 is treated as 1.
- `seek_valid` in 1: seek request.
- `seek_colour` in 3: seek target.
- `seek_ready` out 1: seek acceptance; combinational: `en & !fault & state!=SEEK`.
- `resume` in 1: HOLD→RUN request.
- `colour` in 3: feedback from the colour counter (registered there).
- `button` out 1: step drive to the colour counter; combinational from registered state, `cnt` and `colour`.
- `arrived` out 1: one-cycle pulse when a seek completes.
- `seek_err` out 1: one-cycle pulse when an accepted target is 0 or 7.
- `fault` out 1: sticky fault, cleared only by `rst`.
- `state` out 2: IDLE=0, RUN=1, SEEK=2, HOLD=3.

## Operation
- Reset values: `state`=IDLE, `cnt`=0, `steps`=0, `target`=0, `arrived`=0, `seek_err`=0, `fault`=0, `button`=0.
- `button` by state:
  - IDLE: 0.
  - RUN: `cnt == max(dwell,1)-1`.
  - SEEK: `colour != target`.
  - HOLD: 0.
- Priority of transitions evaluated at each edge: `!en` → IDLE (cnt, steps cleared) > `fault` set → IDLE > seek handshake > `resume` > dwell count.
- IDLE: `en & !fault` → RUN with `cnt`=0.
- RUN:
  - When `cnt` reaches `max(dwell,1)-1`, `cnt` wraps to 0. `button` is high for exactly that cycle, so the counter makes one step.
  - Otherwise `cnt` increments.
  - `dwell` is sampled every cycle. If `dwell` is reduced below `cnt`, `cnt` resets to 0 without a pulse.
- Seek handshake is `seek_valid & seek_ready`, accepted in IDLE, RUN or HOLD.
  - Legal target (1..6): latch `target`, clear `steps`, go to SEEK.
  - Illegal target (0 or 7): pulse `seek_err`. State, `cnt` and `target` are unchanged.
- SEEK:
  - Each edge with `button`=1 increments `steps`.
  - When `colour == target`, `button` is 0 combinationally; at that edge pulse `arrived` and go to HOLD.
  - If the seek is accepted while already at the target, go to SEEK then HOLD with 0 steps.
  - If `steps` reaches 7 without a match: set `fault` and go to IDLE.
- HOLD: `button`=0, colour frozen. `resume` → RUN with `cnt`=0. A new seek is allowed from HOLD.
- `resume` outside HOLD is ignored.
- `rst` at any point, including mid-SEEK: all reset values next cycle and the target is discarded.

## Timing
- RUN with `dwell`=D≥1: `button` pulses 1 cycle in every D, and the colour changes every D cycles.
- The first RUN pulse comes D cycles after the IDLE→RUN edge.
- With `dwell`=0 or 1, `button` is high every RUN cycle and the colour advances every cycle.
- Seek latency: colour reaches the target N edges after the accept edge, where N = forward distance 0..5 (wraps 6→1). `arrived` is registered and asserts 1 cycle after that.
- `seek_ready` deasserts the cycle after acceptance and reasserts on leaving SEEK.
- `en` falling: `button`=0 from the next cycle. Any dwell pulse is lost.
- There is no combinational path from `button` to `colour`. The loop is broken by the counter's register.

## Configuration
- `COLOUR_CHECK_EN`:
  - Defined: `colour` of 0 or 7 sampled while `rst`=0 sets `fault` and forces IDLE on the same edge.
  - Undefined: `colour` is not checked, and `fault` arises only from seek timeout.

## Test plan
- Reset, then `en`=1 with `dwell`=3 → `button` pulses at cycles 3, 6, 9; colour steps 1→2→3→4; no other `button` highs.
- `dwell`=0 in RUN → `button` high continuously; colour 1,2,…,6,1 each cycle.
- From colour 2 in RUN, seek 5 → `button` high 3 cycles, colour 5, `arrived` pulse, state HOLD, colour held 20 cycles; `resume` → RUN.
- Seek 2 from colour 4 → wrap 4,5,6,1,2 (4 steps), HOLD. Seek 7 → `seek_err` pulse, state unchanged. Seek while in SEEK → `seek_ready`=0, not accepted.
- Stubbed colour stuck at 3, seek 6 → 7 `button` cycles, `fault`=1, IDLE, `seek_ready`=0 until `rst`. With `COLOUR_CHECK_EN`, force colour 0 → `fault` next edge.
- `rst` mid-SEEK → next cycle: IDLE, `button`=0, all outputs 0. `en` low mid-RUN → IDLE, no further pulses.
